hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 21 ++
 rtl/sb_match.sv | 28 ++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Entries carry a fixed-width rd so the struct is independent of REG_ADDR_W.
package hazard_scoreboard_pkg;

  localparam int         MAX_PIPE_DEPTH = 8;
  localparam int         MAX_REG_ADDR_W = 8;
  localparam int         IDX_W          = $clog2(MAX_PIPE_DEPTH);
  localparam logic [3:0] FWD_REGFILE    = 4'd0;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] rd;
    logic                      is_load;
  } sb_entry_t;

  // Bypass code: 0 is the regfile, k names stage k-1.
  function automatic logic [3:0] fwd_code(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} + 4'd1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one source register against every in-flight entry and reports
// whether any matches and the index of the youngest (lowest-index) match.
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  sb_entry_t [PIPE_DEPTH-1:0]   entries,
  input  logic [MAX_REG_ADDR_W-1:0]    src_addr,
  input  logic                         src_used,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (src_used && (src_addr != '0) && entries[k].valid && (entries[k].rd == src_addr)) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard producing stall and bypass selects.
// Define HAZARD_FWD_EN for forwarding mode (stall only on load-use).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_rf_w_en,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  flush,
  output logic                  stall_o,
  output logic [3:0]            fwd1_sel,
  output logic [3:0]            fwd2_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  sb_entry_t [PIPE_DEPTH-1:0] pipe;
  logic                       hit1, hit2;
  logic [IDX_W-1:0]           idx1, idx2;
  logic                       issue_accept;

  sb_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_rs1 (
    .entries  (pipe),
    .src_addr (MAX_REG_ADDR_W'(rs1_addr)),
    .src_used (rs1_used),
    .hit      (hit1),
    .idx      (idx1)
  );

  sb_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_rs2 (
    .entries  (pipe),
    .src_addr (MAX_REG_ADDR_W'(rs2_addr)),
    .src_used (rs2_used),
    .hit      (hit2),
    .idx      (idx2)
  );

  always_comb begin
    stall_o  = 1'b0;
    fwd1_sel = FWD_REGFILE;
    fwd2_sel = FWD_REGFILE;
`ifdef HAZARD_FWD_EN
    // Only a load still in EX cannot be bypassed; everything else forwards.
    if (issue_valid && !flush) begin
      stall_o = (hit1 && (idx1 == '0) && pipe[0].is_load) ||
                (hit2 && (idx2 == '0) && pipe[0].is_load);
    end
    if (!stall_o) begin
      if (hit1) fwd1_sel = fwd_code(idx1);
      if (hit2) fwd2_sel = fwd_code(idx2);
    end
`else
    if (issue_valid && !flush) begin
      stall_o = hit1 || hit2;
    end
`endif
  end

  assign issue_accept = issue_valid && issue_rf_w_en && (issue_rd != '0) && !stall_o && !flush;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe      <= '0;
      stall_cnt <= '0;
    end else begin
      pipe[0] <= issue_accept ? '{valid: 1'b1, rd: MAX_REG_ADDR_W'(issue_rd), is_load: issue_is_load}
                              : '0;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        pipe[k] <= pipe[k-1];
      end
      if (stall_o && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Bits that retire without being read.
  logic unused_bits;
`ifdef HAZARD_FWD_EN
  assign unused_bits = pipe[PIPE_DEPTH-1].is_load;
`else
  assign unused_bits = ^{pipe[PIPE_DEPTH-1].is_load, idx1, idx2};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FWD_EN.
// A second instance (PIPE_DEPTH=5, CNT_W=2) exercises counter saturation.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_rf_w_en, issue_is_load;
  logic [4:0] issue_rd, rs1_addr, rs2_addr;
  logic       rs1_used, rs2_used, flush;

  logic        stall_o, stall_s;
  logic [3:0]  fwd1_sel, fwd2_sel, fwd1_s, fwd2_s;
  logic [15:0] stall_cnt;
  logic [1:0]  cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rf_w_en(issue_rf_w_en), .issue_is_load(issue_is_load),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .flush(flush), .stall_o(stall_o), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.PIPE_DEPTH(5), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rf_w_en(issue_rf_w_en), .issue_is_load(issue_is_load),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .flush(flush), .stall_o(stall_s), .fwd1_sel(fwd1_s), .fwd2_sel(fwd2_s),
    .stall_cnt(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rf_w_en = 0; issue_is_load = 0; issue_rd = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0; flush = 0;
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic producer(input logic [4:0] rd, input logic is_load);
    idle();
    issue_valid = 1; issue_rf_w_en = 1; issue_rd = rd; issue_is_load = is_load;
  endtask

  task automatic consumer(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
    idle();
    issue_valid = 1; rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    #1;
    // Reset held for three cycles.
    tick(); tick(); tick();
    check("cnt_in_reset", stall_cnt, 0);
    check("cnt_small_in_reset", cnt_s, 0);
    reset = 0;
    settle();
    check("idle_stall", stall_o, 0);
    check("idle_fwd1", fwd1_sel, 0);
    check("idle_fwd2", fwd2_sel, 0);
    check("idle_cnt", stall_cnt, 0);

`ifdef HAZARD_FWD_EN
    // ALU producer forwards from EX, then from the next stage.
    producer(5, 0); tick();
    consumer(5, 1, 0, 0); settle();
    check("alu_stall", stall_o, 0);
    check("alu_fwd1_ex", fwd1_sel, 1);
    tick();
    check("alu_fwd1_s1", fwd1_sel, 2);
    tick();
    check("alu_fwd1_s2", fwd1_sel, 3);
    tick();
    check("alu_fwd1_retired", fwd1_sel, 0);
    // Load-use: one stall, then forward from stage 1.
    producer(7, 1); tick();
    consumer(0, 0, 7, 1); settle();
    check("lu_stall", stall_o, 1);
    check("lu_fwd2_during_stall", fwd2_sel, 0);
    tick();
    check("lu_stall_after", stall_o, 0);
    check("lu_fwd2", fwd2_sel, 2);
    check("lu_cnt", stall_cnt, 1);
    tick(); tick();
`else
    // Stall until the producer retires from the last tracked stage.
    producer(5, 0); tick();
    consumer(5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("nofwd_stall_%0d", i), stall_o, 1);
      tick();
    end
    settle();
    check("nofwd_stall_end", stall_o, 0);
    check("nofwd_fwd1", fwd1_sel, 0);
    check("nofwd_cnt", stall_cnt, 3);
`endif

    // Register 0 is never tracked.
    producer(0, 0); tick();
    consumer(0, 1, 0, 1); settle();
    check("r0_stall", stall_o, 0);
    check("r0_fwd1", fwd1_sel, 0);
    tick();

    // A flushed producer never enters the scoreboard.
    producer(9, 0); flush = 1; tick();
    consumer(9, 1, 0, 0); settle();
    check("flush_stall", stall_o, 0);
    check("flush_fwd1", fwd1_sel, 0);
    tick();
    check("flush_fwd1_later", fwd1_sel, 0);

    // Flush and an idle decode both mask a real hazard.
    idle(); tick(); tick(); tick();
    producer(5, 1); tick();
    consumer(5, 1, 0, 0); flush = 1; settle();
    check("flush_masks_stall", stall_o, 0);
    flush = 0; issue_valid = 0; settle();
    check("novalid_masks_stall", stall_o, 0);

    // Reset asserted mid-stall clears state without a clock edge.
    do_reset();
    producer(6, 1); tick();
    consumer(6, 1, 0, 0); settle();
    check("pre_reset_stall", stall_o, 1);
    #1 reset = 1;
    #1;
    check("async_reset_stall", stall_o, 0);
    check("async_reset_cnt", stall_cnt, 0);
    tick();
    reset = 0;
    settle();
    check("post_reset_stall", stall_o, 0);

    // Saturation on the 2-bit counter.
    do_reset();
`ifdef HAZARD_FWD_EN
    for (int i = 0; i < 5; i++) begin
      producer(7, 1); tick();
      consumer(0, 0, 7, 1); tick();
    end
    idle(); settle();
    check("sat_main_cnt", stall_cnt, 5);
`else
    producer(5, 0); tick();
    consumer(5, 1, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    settle();
    check("sat_small_stall_end", stall_s, 0);
    check("sat_main_cnt", stall_cnt, 3);
`endif
    check("sat_small_cnt", cnt_s, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
